// File: rtl/timer_countdown.sv
// timer_countdown: microwave MM:SS BCD cook-time entry register and 1 Hz down-counter.
// Ports: clock/clearn, D/loadn digit entry, pgt_1Hz tick, countn enable, BCD digits, zero, done.
module timer_countdown #(
    parameter logic [3:0] SEC_TENS_RELOAD = 4'd5,
    parameter logic       TICK_EDGE_RESET = 1'b1
) (
    input  logic       clock,
    input  logic       clearn,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       countn,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       done
);

    logic       loadn_q;
    logic       pgt_q;
    logic       done_q;
    logic [3:0] mt_q, mo_q, st_q, so_q;
    logic [3:0] mt_d, mo_d, st_d, so_d;
    logic       done_d;
    logic       load_evt;
    logic       tick_evt;

    assign load_evt = !loadn && loadn_q;
    assign tick_evt = pgt_1Hz && !pgt_q;

    assign zero     = ~|{mt_q, mo_q, st_q, so_q};
    assign done     = done_q;
    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;

    always_comb begin
        mt_d   = mt_q;
        mo_d   = mo_q;
        st_d   = st_q;
        so_d   = so_q;
        done_d = 1'b0;
        if (load_evt && countn) begin
            // out-of-range keys are swallowed
            if (D <= 4'd9) begin
                mt_d = mo_q;
                mo_d = st_q;
                st_d = so_q;
                so_d = D;
            end
        end else if (tick_evt && !countn && !zero) begin
            if (so_q != 4'd0) begin
                so_d = so_q - 4'd1;
            end else begin
                so_d = 4'd9;
                if (st_q != 4'd0) begin
                    st_d = st_q - 4'd1;
                end else begin
                    st_d = SEC_TENS_RELOAD;
                    if (mo_q != 4'd0) begin
                        mo_d = mo_q - 4'd1;
                    end else begin
                        // nonzero count guarantees min_tens > 0 here
                        mo_d = 4'd9;
                        mt_d = mt_q - 4'd1;
                    end
                end
            end
            done_d = ~|{mt_d, mo_d, st_d, so_d};
        end
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            loadn_q <= 1'b1;
            pgt_q   <= TICK_EDGE_RESET;
            done_q  <= 1'b0;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
        end else begin
            loadn_q <= loadn;
            pgt_q   <= pgt_1Hz;
            done_q  <= done_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
        end
    end

endmodule
